// File: rtl/mem_port_arbiter_if.sv
// Client-side and memory-side signal bundle for mem_port_arbiter.
// master = arbiter view, slave = clients plus memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned BEAT_BYTES = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LEN_W      = 16
);
  localparam int unsigned DATA_W = BEAT_BYTES * 8;

  logic [NUM_CH-1:0]        ch_start;
  logic [NUM_CH*ADDR_W-1:0] ch_base_addr;
  logic [NUM_CH*LEN_W-1:0]  ch_len;
  logic [NUM_CH-1:0]        ch_is_write;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_ack;
  logic [NUM_CH-1:0]        ch_rvalid;
  logic [DATA_W-1:0]        ch_rdata;
  logic [NUM_CH-1:0]        ch_done;
  logic [NUM_CH-1:0]        ch_busy;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_write_data;
  logic                     mem_read;
  logic                     mem_write;
  logic                     mem_valid;
  logic [DATA_W-1:0]        mem_read_data;
  logic                     err_timeout;

  modport master (
    input  ch_start, ch_base_addr, ch_len, ch_is_write, ch_req, ch_wdata,
    input  mem_valid, mem_read_data,
    output ch_ack, ch_rvalid, ch_rdata, ch_done, ch_busy,
    output mem_addr, mem_write_data, mem_read, mem_write, err_timeout
  );

  modport slave (
    output ch_start, ch_base_addr, ch_len, ch_is_write, ch_req, ch_wdata,
    output mem_valid, mem_read_data,
    input  ch_ack, ch_rvalid, ch_rdata, ch_done, ch_busy,
    input  mem_addr, mem_write_data, mem_read, mem_write, err_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin N-channel descriptor arbiter onto a single memory port.
// Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned BEAT_BYTES  = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.master bus
);
  localparam int unsigned DATA_W = BEAT_BYTES * 8;
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     last_grant_q, last_grant_d;
  logic [CH_W-1:0]     gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q [NUM_CH];
  logic [ADDR_W-1:0]   addr_d [NUM_CH];
  logic [LEN_W-1:0]    rem_q  [NUM_CH];
  logic [LEN_W-1:0]    rem_d  [NUM_CH];
  logic [NUM_CH-1:0]   dir_q, dir_d;
  logic [NUM_CH-1:0]   busy_q, busy_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic [NUM_CH-1:0]   rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic [NUM_CH-1:0]   ack_c;
  logic [NUM_CH-1:0]   elig_c;
  logic                found_c;
  logic [CH_W-1:0]     pick_c;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
`endif

  // A channel whose done is pulsing is still busy but has no beats left.
  assign elig_c = bus.ch_req & busy_q & ~done_q;

  // First eligible channel after the last grant, wrapping modulo NUM_CH.
  always_comb begin
    int unsigned idx;
    found_c = 1'b0;
    pick_c  = last_grant_q;
    idx     = 0;
    for (int k = 1; k <= int'(NUM_CH); k++) begin
      idx = (32'(last_grant_q) + 32'(k)) % NUM_CH;
      if (!found_c && elig_c[CH_W'(idx)]) begin
        found_c = 1'b1;
        pick_c  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    dir_d        = dir_q;
    busy_d       = busy_q & ~done_q;
    done_d       = '0;
    rvalid_d     = '0;
    rdata_d      = rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    ack_c        = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = '0;
    err_d        = err_q;
`endif

    // Descriptor loads; a zero-length descriptor completes immediately.
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (bus.ch_start[i] && !busy_q[i]) begin
        if (bus.ch_len[i*LEN_W +: LEN_W] == '0) begin
          done_d[i] = 1'b1;
        end else begin
          addr_d[i] = bus.ch_base_addr[i*ADDR_W +: ADDR_W];
          rem_d[i]  = bus.ch_len[i*LEN_W +: LEN_W];
          dir_d[i]  = bus.ch_is_write[i];
          busy_d[i] = 1'b1;
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (found_c) begin
          ack_c[pick_c] = 1'b1;
          gnt_d         = pick_c;
          last_grant_d  = pick_c;
          mem_addr_d    = addr_q[pick_c];
          if (dir_q[pick_c]) begin
            mem_wdata_d = bus.ch_wdata[32'(pick_c)*DATA_W +: DATA_W];
            mem_wr_d    = 1'b1;
          end else begin
            mem_rd_d    = 1'b1;
          end
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.mem_valid) begin
          mem_rd_d      = 1'b0;
          mem_wr_d      = 1'b0;
          addr_d[gnt_q] = addr_q[gnt_q] + ADDR_W'(BEAT_BYTES);
          rem_d[gnt_q]  = rem_q[gnt_q] - LEN_W'(1);
          if (!dir_q[gnt_q]) begin
            rvalid_d[gnt_q] = 1'b1;
            rdata_d         = bus.mem_read_data;
          end
          if (rem_q[gnt_q] == LEN_W'(1)) done_d[gnt_q] = 1'b1;
          state_d = S_IDLE;
        end else begin
`ifdef MEM_ARB_TIMEOUT_EN
          // Abort a stalled beat and drop the descriptor silently.
          if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            err_d         = 1'b1;
            mem_rd_d      = 1'b0;
            mem_wr_d      = 1'b0;
            rem_d[gnt_q]  = '0;
            busy_d[gnt_q] = 1'b0;
            state_d       = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= CH_W'(NUM_CH - 1);
      gnt_q        <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        addr_q[i] <= '0;
        rem_q[i]  <= '0;
      end
      dir_q        <= '0;
      busy_q       <= '0;
      done_q       <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  // Grant is combinational so a new beat can issue every second cycle.
  assign bus.ch_ack         = ack_c;
  assign bus.ch_rvalid      = rvalid_q;
  assign bus.ch_rdata       = rdata_q;
  assign bus.ch_done        = done_q;
  assign bus.ch_busy        = busy_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.mem_read       = mem_rd_q;
  assign bus.mem_write      = mem_wr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected memory,
// read-data and done events; a monitor pops them as the DUT produces them.
module tb_mem_port_arbiter;
  localparam int unsigned NUM_CH      = 3;
  localparam int unsigned BEAT_BYTES  = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned LEN_W       = 16;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned DATA_W      = BEAT_BYTES * 8;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_exp_t;

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] data;
  } rv_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_hang;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   stb_cycles = 0;
  int   ack_cnt  [NUM_CH];
  int   ack_base [NUM_CH];

  mem_exp_t q_mem [$];
  rv_exp_t  q_rv  [$];
  int       q_done[$];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_CH(NUM_CH), .BEAT_BYTES(BEAT_BYTES),
                        .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  mem_port_arbiter #(.NUM_CH(NUM_CH), .BEAT_BYTES(BEAT_BYTES), .ADDR_W(ADDR_W),
                     .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [DATA_W-1:0] rdp(input logic [ADDR_W-1:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  function automatic logic [DATA_W-1:0] wdp(input int ch, input int k);
    logic [31:0] w;
    w = 32'hD000_0000 | (32'(ch) << 8) | 32'(k);
    return {8{w}};
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [DATA_W-1:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=%0h required=no-event t=%0t", name, act, $time);
  endtask

  // Memory model: completes each strobe on its second cycle unless hung.
  initial begin
    int scnt;
    scnt = 0;
    bus.mem_valid     = 1'b0;
    bus.mem_read_data = '0;
    forever begin
      @(negedge clk);
      bus.mem_valid = 1'b0;
      if ((bus.mem_read || bus.mem_write) && !mem_hang) begin
        if (scnt == 1) begin
          bus.mem_valid     = 1'b1;
          bus.mem_read_data = rdp(bus.mem_addr);
          scnt = 0;
        end else begin
          scnt++;
        end
      end else begin
        scnt = 0;
      end
    end
  end

  // Client model: advance each channel's write data after every ack.
  initial begin
    logic [NUM_CH-1:0] acked;
    for (int i = 0; i < int'(NUM_CH); i++) ack_cnt[i] = 0;
    bus.ch_wdata = '0;
    forever begin
      @(negedge clk);
      acked = bus.ch_ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (acked[i]) ack_cnt[i]++;
        bus.ch_wdata[i*DATA_W +: DATA_W] = wdp(i, ack_cnt[i] - ack_base[i]);
      end
    end
  end

  // Monitor: pop and compare whenever the DUT presents an event.
  initial begin
    logic              prev_stb, stb;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_wdata;
    mem_exp_t          me;
    rv_exp_t           re;
    int                de;
    prev_stb = 1'b0;
    prev_addr = '0;
    prev_wdata = '0;
    forever begin
      @(negedge clk);
      stb = bus.mem_read | bus.mem_write;
      if (stb) begin
        stb_cycles++;
        chk("single_strobe", DATA_W'(bus.mem_read & bus.mem_write), '0);
      end
      if (stb && !prev_stb) begin
        if (q_mem.size() == 0) unexpected("mem_strobe", DATA_W'(bus.mem_addr));
        else begin
          me = q_mem.pop_front();
          chk("mem_dir", DATA_W'(bus.mem_write), DATA_W'(me.wr));
          chk("mem_addr", DATA_W'(bus.mem_addr), DATA_W'(me.addr));
          if (me.wr) chk("mem_wdata", bus.mem_write_data, me.data);
        end
      end else if (stb) begin
        chk("addr_stable", DATA_W'(bus.mem_addr), DATA_W'(prev_addr));
        chk("wdata_stable", bus.mem_write_data, prev_wdata);
      end
      if (bus.ch_rvalid != '0) begin
        if (q_rv.size() == 0) unexpected("ch_rvalid", DATA_W'(bus.ch_rvalid));
        else begin
          re = q_rv.pop_front();
          chk("rvalid_ch", DATA_W'(bus.ch_rvalid), DATA_W'(3'b001 << re.ch));
          chk("rdata", bus.ch_rdata, re.data);
        end
      end
      if (bus.ch_done != '0) begin
        if (q_done.size() == 0) unexpected("ch_done", DATA_W'(bus.ch_done));
        else begin
          de = q_done.pop_front();
          chk("done_ch", DATA_W'(bus.ch_done), DATA_W'(3'b001 << de));
        end
      end
      prev_stb   = stb;
      prev_addr  = bus.mem_addr;
      prev_wdata = bus.mem_write_data;
    end
  end

  task automatic start_desc(input int ch, input logic [ADDR_W-1:0] base,
                            input int len, input logic wr, input logic exp_busy);
    @(posedge clk);
    #1;
    if (!bus.ch_busy[ch]) ack_base[ch] = ack_cnt[ch];
    bus.ch_base_addr[ch*ADDR_W +: ADDR_W] = base;
    bus.ch_len[ch*LEN_W +: LEN_W]         = LEN_W'(len);
    bus.ch_is_write[ch]                   = wr;
    bus.ch_start[ch]                      = 1'b1;
    @(posedge clk);
    #1;
    bus.ch_start[ch] = 1'b0;
    @(negedge clk);
    chk("busy_after_start", DATA_W'(bus.ch_busy[ch]), DATA_W'(exp_busy));
  endtask

  task automatic wait_drain(input string name, input int max);
    int n;
    n = 0;
    while ((q_mem.size() + q_rv.size() + q_done.size()) != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_in_time"}, DATA_W'(n < max), DATA_W'(1));
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int c0;
    rst_n            = 1'b0;
    mem_hang         = 1'b0;
    bus.ch_start     = '0;
    bus.ch_base_addr = '0;
    bus.ch_len       = '0;
    bus.ch_is_write  = '0;
    bus.ch_req       = '0;
    for (int i = 0; i < int'(NUM_CH); i++) ack_base[i] = 0;

    repeat (3) @(negedge clk);
    chk("rst_mem_read", DATA_W'(bus.mem_read), '0);
    chk("rst_mem_write", DATA_W'(bus.mem_write), '0);
    chk("rst_mem_addr", DATA_W'(bus.mem_addr), '0);
    chk("rst_busy", DATA_W'(bus.ch_busy), '0);
    chk("rst_done", DATA_W'(bus.ch_done), '0);
    chk("rst_rvalid", DATA_W'(bus.ch_rvalid), '0);
    chk("rst_err", DATA_W'(bus.err_timeout), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round robin: ch0 read and ch2 write interleave; idle ch1 request ignored.
    start_desc(0, 32'h3000, 2, 1'b0, 1'b1);
    start_desc(2, 32'h5000, 2, 1'b1, 1'b1);
    q_mem.push_back('{wr: 1'b0, addr: 32'h3000, data: '0});
    q_mem.push_back('{wr: 1'b1, addr: 32'h5000, data: wdp(2, 0)});
    q_mem.push_back('{wr: 1'b0, addr: 32'h3020, data: '0});
    q_mem.push_back('{wr: 1'b1, addr: 32'h5020, data: wdp(2, 1)});
    q_rv.push_back('{ch: 0, data: rdp(32'h3000)});
    q_rv.push_back('{ch: 0, data: rdp(32'h3020)});
    q_done.push_back(0);
    q_done.push_back(2);
    bus.ch_req = 3'b111;
    wait_drain("rr", 100);
    bus.ch_req = '0;
    chk("rr_busy_clear", DATA_W'(bus.ch_busy), '0);

    // Single read channel, three beats.
    start_desc(0, 32'h1000, 3, 1'b0, 1'b1);
    q_mem.push_back('{wr: 1'b0, addr: 32'h1000, data: '0});
    q_mem.push_back('{wr: 1'b0, addr: 32'h1020, data: '0});
    q_mem.push_back('{wr: 1'b0, addr: 32'h1040, data: '0});
    q_rv.push_back('{ch: 0, data: rdp(32'h1000)});
    q_rv.push_back('{ch: 0, data: rdp(32'h1020)});
    q_rv.push_back('{ch: 0, data: rdp(32'h1040)});
    q_done.push_back(0);
    bus.ch_req[0] = 1'b1;
    wait_drain("rd3", 100);
    bus.ch_req = '0;
    chk("rd3_busy_clear", DATA_W'(bus.ch_busy), '0);

    // Zero-length descriptor: done next cycle, no memory traffic.
    q_done.push_back(1);
    start_desc(1, 32'h9000, 0, 1'b0, 1'b0);
    chk("zero_len_done", DATA_W'(bus.ch_done), DATA_W'(3'b010));
    wait_drain("zero", 20);
    chk("zero_len_no_strobe", DATA_W'(bus.mem_read | bus.mem_write), '0);

    // Restart of a busy channel is ignored.
    start_desc(0, 32'h2000, 4, 1'b0, 1'b1);
    for (int b = 0; b < 4; b++) begin
      q_mem.push_back('{wr: 1'b0, addr: 32'h2000 + 32'(b * 32), data: '0});
      q_rv.push_back('{ch: 0, data: rdp(32'h2000 + 32'(b * 32))});
    end
    q_done.push_back(0);
    bus.ch_req[0] = 1'b1;
    n = 0;
    while ((ack_cnt[0] - ack_base[0]) < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("restart_wait_in_time", DATA_W'(n < 50), DATA_W'(1));
    start_desc(0, 32'h8000, 7, 1'b0, 1'b1);
    wait_drain("restart", 100);
    bus.ch_req = '0;
    chk("restart_busy_clear", DATA_W'(bus.ch_busy), '0);

    // Reset while a read strobe is outstanding.
    mem_hang = 1'b1;
    start_desc(0, 32'h6000, 5, 1'b0, 1'b1);
    q_mem.push_back('{wr: 1'b0, addr: 32'h6000, data: '0});
    bus.ch_req[0] = 1'b1;
    n = 0;
    while (!bus.mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_strobe_seen", DATA_W'(bus.mem_read), DATA_W'(1));
    rst_n = 1'b0;
    bus.ch_req = '0;
    #1;
    chk("rst_mid_mem_read", DATA_W'(bus.mem_read), '0);
    chk("rst_mid_busy", DATA_W'(bus.ch_busy), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mem_hang = 1'b0;
    start_desc(0, 32'h7000, 1, 1'b0, 1'b1);
    q_mem.push_back('{wr: 1'b0, addr: 32'h7000, data: '0});
    q_rv.push_back('{ch: 0, data: rdp(32'h7000)});
    q_done.push_back(0);
    bus.ch_req[0] = 1'b1;
    wait_drain("post_rst", 50);
    bus.ch_req = '0;

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: hung memory aborts the beat after TIMEOUT_CYC strobe cycles.
    mem_hang = 1'b1;
    start_desc(1, 32'hA000, 2, 1'b0, 1'b1);
    q_mem.push_back('{wr: 1'b0, addr: 32'hA000, data: '0});
    c0 = stb_cycles;
    bus.ch_req[1] = 1'b1;
    n = 0;
    while (!bus.err_timeout && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_err", DATA_W'(bus.err_timeout), DATA_W'(1));
    chk("timeout_strobe_cycles", DATA_W'(stb_cycles - c0), DATA_W'(TIMEOUT_CYC));
    chk("timeout_strobe_low", DATA_W'(bus.mem_read), '0);
    chk("timeout_busy_clear", DATA_W'(bus.ch_busy), '0);
    bus.ch_req = '0;
    mem_hang = 1'b0;
    repeat (3) @(negedge clk);
    chk("timeout_err_sticky", DATA_W'(bus.err_timeout), DATA_W'(1));
`else
    c0 = 0;
    chk("err_tied_low", DATA_W'(bus.err_timeout), DATA_W'(c0));
`endif

    repeat (4) @(negedge clk);
    chk("queues_empty", DATA_W'(q_mem.size() + q_rv.size() + q_done.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
